axi_w_mux_ordered: RTL
======================

Name: axi_w_mux_ordered

Overview:
Per-slave AXI write-data (W) channel multiplexer for the interconnect. It generalises the fixed 2-master W mux to MASTER_CNT masters and parametrised data width. W beats are steered strictly in the order the slave's AW handshakes were granted, tracked by an internal order FIFO. One registered output stage decouples master-side timing from slave-side timing. It sits between the masters' W channels and one slave port, driven by that slave's AW arbiter.

Parameters:
MASTER_CNT, 2, number of masters feeding this slave (>=2)
DATA_BITS, 32, W data width; STRB_BITS = DATA_BITS/8 (derived)
ORDER_DEPTH, 4, order FIFO entries (power of 2, >=2); IDX_BITS = $clog2(MASTER_CNT) (derived)
LEN_BITS, 4, AWLEN width (used only with the optional feature)

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
aw_push  in  1  AW handshake for this slave completed this cycle
aw_master  in  IDX_BITS  index of the master whose AW was accepted
aw_len  in  LEN_BITS  AWLEN of that burst
aw_full  out  1  order FIFO full; AW arbiter must not grant
WDATA_MS  in  MASTER_CNT x DATA_BITS  per-master write data
WSTRB_MS  in  MASTER_CNT x STRB_BITS  per-master strobes
WLAST_MS  in  MASTER_CNT  per-master last flag
WVALID_MS  in  MASTER_CNT  per-master valid
WREADY_MS  out  MASTER_CNT  per-master ready
WDATA  out  DATA_BITS  to slave
WSTRB  out  STRB_BITS  to slave
WLAST  out  1  to slave
WVALID  out  1  to slave
WREADY  in  1  from slave
len_err  out  1  sticky burst-length error (feature only; else 0)

Behaviour:
- Reset (async, ARESETn=0): FIFO empty, aw_full=0, WVALID=0, WLAST=0, WDATA=0, WSTRB=all ones, WREADY_MS=0, len_err=0, beat counter=0. Reset mid-burst discards the in-flight beat and all queued entries.
- Order FIFO: read/write pointers with wrap bit. aw_full = (count==ORDER_DEPTH), registered-state only.
- Push: aw_push && !aw_full && aw_master<MASTER_CNT. A push while full is dropped even if a pop occurs in the same cycle. An out-of-range aw_master is dropped.
- No bypass: an entry pushed at edge t becomes head and is usable from cycle t+1.
- Head master h = FIFO head when non-empty. can_load = !WVALID || WREADY.
- WREADY_MS[h] = nonempty && can_load; all other bits 0. Empty FIFO: all 0.
- Beat accept: WVALID_MS[h] && WREADY_MS[h]. Registers WDATA/WSTRB/WLAST from master h and sets WVALID=1.
- Drain: WVALID && WREADY with no accept clears WVALID. Simultaneous drain and accept keeps WVALID=1 with the new beat.
- Latency: 1 cycle master->slave. Throughput: 1 beat/cycle, with no bubble between back-to-back bursts.
- Pop: on an accepted beat with WLAST_MS[h]=1. The next head is selectable in the following cycle.
- Simultaneous push and pop: both occur; count unchanged.
- Idle (WVALID=0): WDATA and WSTRB hold the last beat; WLAST forced 0.
- Slave backpressure (WVALID && !WREADY): all outputs stable; WREADY_MS=0.

Optional Feature:
W_LEN_CHECK_EN:
- Defined: FIFO also stores aw_len. A beat counter counts accepted beats of the head burst and resets to 0 on pop.
- On the beat where count==len, output WLAST is forced to 1 and the FIFO pops regardless of WLAST_MS.
- len_err is set and held until reset if WLAST_MS[h]=1 on a beat where count!=len, or WLAST_MS[h]=0 on a beat where count==len.
- Not defined: aw_len ignored, pop only on WLAST_MS, len_err tied 0, no counter logic.

Test Plan:
1. Reset: ARESETn low mid-burst -> WVALID=0, WLAST=0, WSTRB=4'hF, aw_full=0, WREADY_MS=2'b00. After release, a W beat without a push is not accepted.
2. Ordering: MASTER_CNT=2, push m1 then m0, both masters drive WVALID. WDATA sequence must be m1 beats 0x11,0x12,0x13,0x14 (WLAST on 0x14), then m0 beats 0x21,0x22. WREADY_MS[0]=0 throughout the m1 burst.
3. Backpressure: WREADY=0 for 3 cycles on beat 2 -> WDATA=0x12 held stable, WREADY_MS[1]=0. No beat lost or duplicated after WREADY returns.
4. FIFO full: 4 pushes with no W traffic -> aw_full=1; a 5th push is dropped. After one burst pops, aw_full=0 next cycle; total bursts forwarded = 4.
5. Empty start: WVALID_MS[0]=1 held, push m0 at edge t -> WREADY_MS[0]=1 in cycle t+1, WVALID=1 in cycle t+2.
6. W_LEN_CHECK_EN, two bursts:
   - aw_len=1 with WLAST_MS on beat 0 -> len_err=1.
   - aw_len=3 with WLAST_MS never asserted -> WLAST=1 on beat 4 and the FIFO pops.

Source files
------------

// File: rtl/axi_w_mux_ordered.sv
// Per-slave AXI W-channel mux: steers master W beats to the slave in AW grant order.
// Optional AWLEN checking / WLAST regeneration when W_LEN_CHECK_EN is defined.
module axi_w_mux_ordered #(
   parameter int unsigned MASTER_CNT  = 2,
   parameter int unsigned DATA_BITS   = 32,
   parameter int unsigned ORDER_DEPTH = 4,
   parameter int unsigned LEN_BITS    = 4,
   localparam int unsigned STRB_BITS  = DATA_BITS / 8,
   localparam int unsigned IDX_BITS   = $clog2(MASTER_CNT)
) (
   input  logic                            ACLK,
   input  logic                            ARESETn,
   input  logic                            aw_push,
   input  logic [IDX_BITS-1:0]             aw_master,
   input  logic [LEN_BITS-1:0]             aw_len,
   output logic                            aw_full,
   input  logic [MASTER_CNT*DATA_BITS-1:0] WDATA_MS,
   input  logic [MASTER_CNT*STRB_BITS-1:0] WSTRB_MS,
   input  logic [MASTER_CNT-1:0]           WLAST_MS,
   input  logic [MASTER_CNT-1:0]           WVALID_MS,
   output logic [MASTER_CNT-1:0]           WREADY_MS,
   output logic [DATA_BITS-1:0]            WDATA,
   output logic [STRB_BITS-1:0]            WSTRB,
   output logic                            WLAST,
   output logic                            WVALID,
   input  logic                            WREADY,
   output logic                            len_err
);

   localparam int unsigned PTR_BITS = $clog2(ORDER_DEPTH);
   localparam int unsigned CNT_W    = PTR_BITS + 1;

   logic [CNT_W-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic [IDX_BITS-1:0]  ord_master [ORDER_DEPTH];
   logic                 fifo_empty, full_nxt;
   logic                 push_ok, pop;
   logic [IDX_BITS-1:0]  head;
   logic                 can_load, accept;
   logic                 sel_valid, sel_last, out_last;
   logic [DATA_BITS-1:0] sel_data;
   logic [STRB_BITS-1:0] sel_strb;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign head       = ord_master[rd_ptr[PTR_BITS-1:0]];
   assign push_ok    = aw_push && !aw_full && (32'(aw_master) < MASTER_CNT);
   assign can_load   = !WVALID || WREADY;
   assign accept     = !fifo_empty && can_load && sel_valid;

   // Pointer arithmetic; full flag is registered from the next-state pointers.
   always_comb begin
      wr_ptr_nxt = wr_ptr + CNT_W'(push_ok);
      rd_ptr_nxt = rd_ptr + CNT_W'(pop);
      full_nxt   = (wr_ptr_nxt[PTR_BITS] != rd_ptr_nxt[PTR_BITS]) &&
                   (wr_ptr_nxt[PTR_BITS-1:0] == rd_ptr_nxt[PTR_BITS-1:0]);
   end

   // Select the head master's W signals.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      sel_strb  = '0;
      for (int unsigned i = 0; i < MASTER_CNT; i++) begin
         if (IDX_BITS'(i) == head) begin
            sel_valid = WVALID_MS[i];
            sel_last  = WLAST_MS[i];
            sel_data  = WDATA_MS[i*DATA_BITS +: DATA_BITS];
            sel_strb  = WSTRB_MS[i*STRB_BITS +: STRB_BITS];
         end
      end
   end

   always_comb begin
      WREADY_MS = '0;
      for (int unsigned i = 0; i < MASTER_CNT; i++) begin
         if (IDX_BITS'(i) == head) begin
            WREADY_MS[i] = !fifo_empty && can_load;
         end
      end
   end

`ifdef W_LEN_CHECK_EN
   logic [LEN_BITS-1:0] ord_len [ORDER_DEPTH];
   logic [LEN_BITS-1:0] beat_cnt;
   logic                len_hit;

   // The AWLEN beat count is authoritative for burst end; master WLAST is only checked.
   assign len_hit  = (beat_cnt == ord_len[rd_ptr[PTR_BITS-1:0]]);
   assign out_last = len_hit;
   assign pop      = accept && len_hit;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         beat_cnt <= '0;
         len_err  <= 1'b0;
         for (int unsigned i = 0; i < ORDER_DEPTH; i++) begin
            ord_len[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            ord_len[wr_ptr[PTR_BITS-1:0]] <= aw_len;
         end
         if (pop) begin
            beat_cnt <= '0;
         end else if (accept) begin
            beat_cnt <= beat_cnt + LEN_BITS'(1);
         end
         if (accept && (sel_last != len_hit)) begin
            len_err <= 1'b1;
         end
      end
   end
`else
   logic unused_len;

   assign unused_len = ^aw_len;
   assign out_last   = sel_last;
   assign pop        = accept && sel_last;
   assign len_err    = 1'b0;
`endif

   // Order FIFO state.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         aw_full <= 1'b0;
         for (int unsigned i = 0; i < ORDER_DEPTH; i++) begin
            ord_master[i] <= '0;
         end
      end else begin
         wr_ptr  <= wr_ptr_nxt;
         rd_ptr  <= rd_ptr_nxt;
         aw_full <= full_nxt;
         if (push_ok) begin
            ord_master[wr_ptr[PTR_BITS-1:0]] <= aw_master;
         end
      end
   end

   // Registered slave-side output stage.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         WVALID <= 1'b0;
         WLAST  <= 1'b0;
         WDATA  <= '0;
         WSTRB  <= '1;
      end else if (accept) begin
         WVALID <= 1'b1;
         WLAST  <= out_last;
         WDATA  <= sel_data;
         WSTRB  <= sel_strb;
      end else if (WVALID && WREADY) begin
         WVALID <= 1'b0;
         WLAST  <= 1'b0;
      end
   end

endmodule
